// File: rtl/aes128_decrypt_iter_if.sv
// Purpose: ciphertext/key request and plaintext response channels of the AES-128 decrypt engine.
// Latency: none, signal bundle only.
// Backpressure: valid/ready on both channels; the engine owns in_ready and out_valid.
interface aes128_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Purpose: iterative AES-128 decryption; key expanded forward to K10, then 10 inverse rounds with backward key regeneration.
// Latency: 20 cycles from input handshake to out_valid, 10 when the cached K10 matches in_key; one block in flight.
// Backpressure: in_ready only in IDLE (busy requests dropped); out_valid/out_data held in DONE until out_ready.
module aes128_decrypt_iter #(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes128_decrypt_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   ctr_q, ctr_d;
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_k10_q, cache_k10_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;

  logic [127:0] exp_key, prev_key, rnd_pre, rnd_out;
  logic         cache_hit;

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; the chain lifts the exponent 1->3->7->...->127, then squares. 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-boxes built from the field inverse and the affine map rather than ROM tables.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  // Byte i of the state sits at [127-8i -: 8], i = 4*column + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------- datapath ----------------
  // ctr doubles as the Rcon index: counts up through KEYEXP and down through ROUND.
  assign exp_key  = fwd_expand(rk_q, rcon(ctr_q));
  assign prev_key = inv_expand(rk_q, rcon(ctr_q));
  assign rnd_pre  = inv_sub_bytes(inv_shift_rows(st_q)) ^ prev_key;
  assign rnd_out  = (ctr_q > 4'd1) ? inv_mix_columns(rnd_pre) : rnd_pre;

  assign cache_hit     = KEY_REUSE && cache_vld_q && (bus.in_key == cache_key_q);
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Next-state and datapath update for the IDLE/KEYEXP/ROUND/DONE sequence.
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    rk_d        = rk_q;
    ctr_d       = ctr_q;
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_k10_d = cache_k10_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (cache_hit) begin
            rk_d  = cache_k10_q;
            st_d  = bus.in_data ^ cache_k10_q;
            ctr_d = 4'd10;
            fsm_d = ROUND;
          end else begin
            // The new key is parked in the cache slot now but only marked valid once K10 exists.
            rk_d        = bus.in_key;
            st_d        = bus.in_data;
            ctr_d       = 4'd1;
            cache_vld_d = 1'b0;
            cache_key_d = bus.in_key;
            fsm_d       = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        rk_d  = exp_key;
        ctr_d = ctr_q + 4'd1;
        if (ctr_q == 4'd10) begin
          st_d        = st_q ^ exp_key;
          cache_k10_d = exp_key;
          cache_vld_d = 1'b1;
          ctr_d       = 4'd10;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        st_d  = rnd_out;
        rk_d  = prev_key;
        ctr_d = ctr_q - 4'd1;
        if (ctr_q == 4'd1) begin
          out_data_d  = rnd_out;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register; reset also drops the key cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      ctr_q       <= '0;
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_k10_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      ctr_q       <= ctr_d;
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_k10_q <= cache_k10_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Purpose: scoreboard bench for aes128_decrypt_iter against a byte-array AES-128 encryption model.
// Latency: checks 20-cycle full path and 10-cycle cached-key path per block.
// Backpressure: exercises out_ready held low, random out_ready, busy-time in_valid and mid-operation reset.
module tb_aes128_decrypt_iter;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 0;

  aes128_decrypt_iter_if bus_if ();

  aes128_decrypt_iter #(.KEY_REUSE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] exp_q [$];
  int           lat_q [$];
  int           hs_q  [$];
  bit           tb_cache_ok = 0;
  logic [127:0] tb_cache_key = '0;
  bit           seen = 0;
  bit           hold = 0;
  logic [127:0] hold_dat = '0;
  logic [7:0]   sbox_t [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = tb_xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
          s[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    int n;
    bit rdy;
    bit hit;
    int lat;
    hit = tb_cache_ok && (key == tb_cache_key);
    lat = hit ? 10 : 20;
    if (!hit) begin
      tb_cache_ok  = 1;
      tb_cache_key = key;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = ct;
    bus_if.in_key   = key;
    n = 0;
    do begin
      rdy = bus_if.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 500);
    bus_if.in_valid = 1'b0;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL handshake_timeout in_ready=0 required=1");
    end else begin
      exp_q.push_back(pt);
      lat_q.push_back(lat);
      hs_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete(); lat_q.delete(); hs_q.delete();
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = ($urandom_range(0, 3) != 0);
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on first sight of out_valid, stability while stalled, data on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      hold = 0;
    end else if (bus_if.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out got=%h required=no_output", bus_if.out_data);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 128'(cyc - hs_q[0]), 128'(lat_q[0]));
        end
        if (hold) check("hold_data", bus_if.out_data, hold_dat);
        check("done_in_ready", {127'b0, bus_if.in_ready}, 128'b0);
        if (bus_if.out_ready) begin
          check("plaintext", bus_if.out_data, exp_q[0]);
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(hs_q.pop_front());
          seen = 0;
          hold = 0;
        end else begin
          hold     = 1;
          hold_dat = bus_if.out_data;
        end
      end
    end else if (hold) begin
      checks++; failures++;
      $display("FAIL out_valid_dropped got=0 required=1");
      hold = 0;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] key, pt, ct;
    int n;
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_key   = '0;
    build_sbox();
    #12;
    check("rst_in_ready",  {127'b0, bus_if.in_ready},  128'd1);
    check("rst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    check("rst_out_data",  bus_if.out_data, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Known vectors: full path, cache hit, key change.
    send(C1_KEY, C1_CT, C1_PT);
    drain();
    check("k10_cached", dut.cache_k10_q, C1_K10);
    send(C1_KEY, C1_CT, C1_PT);
    drain();
    send(B_KEY, B_CT, B_PT);
    drain();

    // Back-pressure with busy-time in_valid pulses, then a request waiting across DONE->IDLE.
    rdy_mode = 2;
    @(posedge clk); #1;
    send(B_KEY, B_CT, B_PT);
    repeat (3) begin @(posedge clk); #1; end
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
    bus_if.in_key   = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) begin
      check("busy_in_ready", {127'b0, bus_if.in_ready}, 128'd0);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    n = 0;
    while (!bus_if.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid", {127'b0, bus_if.out_valid}, 128'd1);
    repeat (7) begin
      @(posedge clk); #1;
      check("bp_valid_held", {127'b0, bus_if.out_valid}, 128'd1);
    end
    fork
      send(C1_KEY, C1_CT, C1_PT);
      begin
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    drain();

    // Reset during ROUND of a full-path block: cache must be forgotten.
    send(B_KEY, B_CT, B_PT);
    drain();
    send(C1_KEY, C1_CT, C1_PT);
    repeat (13) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    check("abort_in_ready",  {127'b0, bus_if.in_ready},  128'd1);
    check("abort_out_data",  bus_if.out_data, 128'd0);
    exp_q.delete(); lat_q.delete(); hs_q.delete();
    tb_cache_ok = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    send(C1_KEY, C1_CT, C1_PT);
    drain();

    // Random traffic with random out_ready; some keys repeat to exercise the cache.
    rdy_mode = 1;
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 50; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(key, pt);
      send(key, ct, pt);
    end
    drain();
    rdy_mode = 0;
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Iterative AES-128 decryption engine: the inverse companion of the per-round encryption datapath.
- Accepts one 128-bit ciphertext plus the original cipher key over a valid/ready input handshake.
- Expands the key forward to K10, then runs 10 inverse rounds at one round per clock, regenerating round keys backward on the fly.
- Presents the plaintext over a valid/ready output handshake; sits beside the encryption core in the AES top level.

Parameters:
KEY_REUSE, 1, when 1 a cached K10 from the previous operation is reused if in_key matches the cached key, skipping key expansion; when 0 the cache is never used.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ciphertext/key valid
in_ready  output  1  engine can accept; high only in IDLE
in_data  input  128  ciphertext; [127:120] is byte 0, column-major state
in_key  input  128  original cipher key K0, same byte order
out_valid  output  1  plaintext valid; held until accepted
out_ready  input  1  consumer accepts plaintext
out_data  output  128  plaintext, same byte order

Behaviour:
- Reset state (async, on rst high): FSM=IDLE; in_ready=1; out_valid=0; out_data=0; round counter=0; key cache invalid; cached key/K10=0.
- FSM states are IDLE, KEYEXP, ROUND and DONE.
- IDLE:
  - On an edge with in_valid & in_ready, latch in_data and in_key.
  - If KEY_REUSE=1, the cache is valid and in_key == cached K0: load the cached K10, set state=in_data^K10, set rnd=10, go to ROUND.
  - Otherwise load rk=in_key, set cnt=1, go to KEYEXP.
- KEYEXP:
  - Each edge: rk <= forward_expand(rk, Rcon[cnt]), then cnt++.
  - Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - On the edge with cnt=10: rk=K10; state <= ct^K10; K0 and K10 are written to the cache and the cache marked valid; rnd=10; go to ROUND.
- ROUND, each edge:
  - Compute the previous round key k = inverse_expand(rk, Rcon[rnd]):
    - w3'=w3^w2; w2'=w2^w1; w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^Rcon
  - Update state <= InvShiftRows, then InvSubBytes, then XOR k; apply InvMixColumns after the XOR only when rnd>1.
  - rk<=k; rnd--.
  - On the edge with rnd=1: out_data<=result, out_valid<=1, go to DONE.
- DONE: hold out_data and out_valid; on an edge with out_valid & out_ready, set out_valid=0 and go to IDLE.
- Latency, measured from the input handshake edge to out_valid high:
  - 20 cycles full path (10 KEYEXP + 10 ROUND).
  - 10 cycles on a cache hit.
- Throughput: one block in flight; in_ready=0 in KEYEXP, ROUND and DONE. in_valid during a busy period is ignored and not queued.
- Output back-pressure: out_ready low holds DONE indefinitely; out_data must stay stable.
- Simultaneity: out_ready & out_valid in DONE and in_valid in the same cycle do not start a new operation; in_ready rises the cycle after the return to IDLE.
- Reset mid-operation: all state and the cache clear immediately; no out_valid is produced for the aborted block.
- Key schedule S-box uses the forward S-box; the data path uses the inverse S-box, InvShiftRows and InvMixColumns (GF(2^8), poly 0x11b, coefficients 0e,0b,0d,09).
- Parameter KEY_REUSE=0 ties the cache-hit compare to 0.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff; out_valid exactly 20 cycles after the handshake; internal K10=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Cache hit: repeat C.1 with the same key (KEY_REUSE=1) -> same plaintext, latency 10; repeat with the App B key -> latency 20.
- Back-pressure: hold out_ready=0 for 7 cycles -> out_valid/out_data stable, in_ready=0; pulse in_valid during busy -> ignored; after out_ready, the next block starts only on an in_valid seen in IDLE.
- Reset mid-ROUND (assert rst at cycle 14) -> out_valid=0, in_ready=1 immediately; the next C.1 request takes 20 cycles (cache cleared) and decrypts correctly.
- Back-to-back: 50 random key/pt pairs encrypted by the reference model -> all decrypt correctly with out_ready randomised.
